// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: frame FSM states, sync marker
// and default geometry of the program RAM.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 14;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
        S_CHK     = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_e;

endpackage

// File: rtl/prog_ram_2048x14.sv
// Program RAM: one clocked write port, one asynchronous read port that
// stands in for the old instruction ROM.
module prog_ram_2048x14 #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: assembles 14-bit words into the program RAM and
// holds the CPU in reset until a frame with a good checksum has landed.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam logic [16:0] MAX_N = 17'(2**ADDR_W);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        lo_q, lo_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic              we;
    logic              fire;
    logic [7:0]        acc_sum;
    logic [DATA_W-1:0] wdata;

    assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
    assign fire      = in_valid && in_ready;
    assign acc_sum   = acc_q + in_data;
    // Upper HI bits beyond the word width are dropped here but still summed.
    assign wdata     = {in_data[DATA_W-9:0], lo_q};
    assign load_done = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = hold_q;
    assign load_err  = err_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        hold_d  = hold_q;
        err_d   = err_q;
        we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire && in_data == SYNC_BYTE) begin
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    wptr_d  = '0;
                    acc_d   = '0;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (fire) begin
                    cnt_d   = {8'h00, in_data};
                    acc_d   = acc_sum;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (fire) begin
                    cnt_d = {in_data, cnt_q[7:0]};
                    acc_d = acc_sum;
                    if ({1'b0, cnt_d} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (cnt_d == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (fire) begin
                    lo_d    = in_data;
                    acc_d   = acc_sum;
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (fire) begin
                    we      = 1'b1;
                    acc_d   = acc_sum;
                    wptr_d  = wptr_q + 1'b1;
                    cnt_d   = cnt_q - 16'd1;
                    state_d = (cnt_q == 16'd1) ? S_CHK : S_DATA_LO;
                end
            end
            S_CHK: begin
                if (fire) begin
                    if (in_data == acc_q) begin
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            hold_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Reset beats a coincident HI byte, so its write is dropped too.
    prog_ram_2048x14 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we && !reset),
        .waddr_i (wptr_q),
        .wdata_i (wdata),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

endmodule
